stream_mux_arb: RTL and testbench

Parametrised N-to-1 stream multiplexer with built-in arbitration and a registered output stage. It generalises the combinational 2:1 datapath select to N valid/ready channels of configurable width. Channels are picked by round-robin, fixed-priority or forced selection. It sits between multiple producers (e.g. instruction-fetch, load/store and debug requesters) and a single shared consumer such as the memory port. Every transfer incurs exactly one cycle of latency.

---
 rtl/stream_mux_arb.sv | 98 +++++++++
 tb/tb_stream_mux_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_arb.sv
// N-to-1 valid/ready stream mux with round-robin, fixed-priority or
// forced arbitration feeding a single-entry registered output stage.
module stream_mux_arb #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 force_en,
    input  logic [SELW-1:0]      force_sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  hi_idx;
    logic [SELW-1:0]  lo_idx;
    logic [SELW-1:0]  nxt_ptr;
    logic [N-1:0]     elig;
    logic             hi_found;
    logic             can_acc;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    int               start;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            if (force_en)
                elig[i] = in_valid[i] && (force_sel == SELW'(i));
            else
                elig[i] = in_valid[i];
        end
    end

    // Rotating scan: first eligible at or above start, else lowest overall.
    always_comb begin
        start    = (MODE == 0) ? int'(ptr) : 0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_idx = SELW'(i);
                if (i >= start) begin
                    hi_idx   = SELW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        grant = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i))
                sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign can_acc = !out_valid || out_ready;
    assign nxt_ptr = (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        in_ready = '0;
        if (rst_n && can_acc && (|elig))
            in_ready[grant] = 1'b1;
    end

    assign xfer = |in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant;
            if (MODE == 0 || force_en)
                ptr <= nxt_ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Scoreboard bench for stream_mux_arb: round-robin, fixed-priority
// and a narrow two-channel instance, with directed vectors.
module tb_stream_mux_arb;

    typedef struct packed {
        logic [31:0] sel;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [127:0] d0_data;
    logic [3:0]   d0_valid, d0_rdy;
    logic         d0_fen, d0_ov, d0_ordy;
    logic [1:0]   d0_fsel, d0_osel;
    logic [31:0]  d0_odata;

    logic [127:0] d1_data;
    logic [3:0]   d1_valid, d1_rdy;
    logic         d1_fen, d1_ov, d1_ordy;
    logic [1:0]   d1_fsel, d1_osel;
    logic [31:0]  d1_odata;

    logic [15:0]  d2_data;
    logic [1:0]   d2_valid, d2_rdy;
    logic         d2_fen, d2_ov, d2_ordy;
    logic [0:0]   d2_fsel, d2_osel;
    logic [7:0]   d2_odata;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   ncmp;
    int   nerr;

    stream_mux_arb #(.WIDTH(32), .N(4), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .in_data(d0_data), .in_valid(d0_valid), .in_ready(d0_rdy),
        .force_en(d0_fen), .force_sel(d0_fsel),
        .out_data(d0_odata), .out_sel(d0_osel),
        .out_valid(d0_ov), .out_ready(d0_ordy)
    );

    stream_mux_arb #(.WIDTH(32), .N(4), .MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .in_data(d1_data), .in_valid(d1_valid), .in_ready(d1_rdy),
        .force_en(d1_fen), .force_sel(d1_fsel),
        .out_data(d1_odata), .out_sel(d1_osel),
        .out_valid(d1_ov), .out_ready(d1_ordy)
    );

    stream_mux_arb #(.WIDTH(8), .N(2), .MODE(0)) u_n2 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d2_data), .in_valid(d2_valid), .in_ready(d2_rdy),
        .force_en(d2_fen), .force_sel(d2_fsel),
        .out_data(d2_odata), .out_sel(d2_osel),
        .out_valid(d2_ov), .out_ready(d2_ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int s, input logic [31:0] d);
        exp_t e;
        e.sel  = 32'(s);
        e.data = d;
        return e;
    endfunction

    function automatic logic [127:0] defdata();
        return {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && d0_ov && d0_ordy) begin
            if (q0.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL m0 extra: got sel %0d data %h, expected none",
                         d0_osel, d0_odata);
            end else begin
                chk("m0 out", {32'(d0_osel), d0_odata}, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && d1_ov && d1_ordy) begin
            if (q1.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL m1 extra: got sel %0d data %h, expected none",
                         d1_osel, d1_odata);
            end else begin
                chk("m1 out", {32'(d1_osel), d1_odata}, q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && d2_ov && d2_ordy) begin
            if (q2.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL m2 extra: got sel %0d data %h, expected none",
                         d2_osel, d2_odata);
            end else begin
                chk("m2 out", {32'(d2_osel), 24'h0, d2_odata}, q2.pop_front());
            end
        end
    end

    initial begin
        ncmp = 0;
        nerr = 0;
        rst_n = 1'b0;
        d0_data = defdata(); d0_valid = 4'hF; d0_fen = 0;
        d0_fsel = 0; d0_ordy = 1;
        d1_data = defdata(); d1_valid = 4'hF; d1_fen = 0;
        d1_fsel = 0; d1_ordy = 1;
        d2_data = {8'hA5, 8'h3C}; d2_valid = 2'b11; d2_fen = 0;
        d2_fsel = 0; d2_ordy = 1;

        #2;
        chk("reset0", {d0_ov, d0_osel, d0_odata, d0_rdy}, 64'h0);
        chk("reset1 rdy", {60'h0, d1_rdy}, 64'h0);
        chk("reset2 rdy", {62'h0, d2_rdy}, 64'h0);

        @(posedge clk);
        @(posedge clk);
        #1;
        d1_valid = 4'h0;
        d2_valid = 2'b00;
        foreach (q0[i]) q0.delete(i);
        q0.push_back(mk(0, 32'hA0000000));
        q0.push_back(mk(1, 32'hA0000001));
        q0.push_back(mk(2, 32'hA0000002));
        q0.push_back(mk(3, 32'hA0000003));
        q0.push_back(mk(0, 32'hA0000000));
        q0.push_back(mk(1, 32'hA0000001));
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        d0_valid = 4'h0;
        @(posedge clk);
        #1;
        chk("rr drained", {63'h0, d0_ov}, 64'h0);

        d0_data[2*32 +: 32] = 32'hDEADBEEF;
        d0_valid = 4'b0100;
        d0_ordy = 0;
        @(posedge clk);
        #1;
        chk("pre-reset load", {d0_ov, d0_osel, d0_odata}, {1'b1, 2'd2, 32'hDEADBEEF});
        d0_valid = 4'hF;
        #2;
        rst_n = 1'b0;
        d0_ordy = 1;
        #1;
        chk("async reset", {d0_ov, d0_osel, d0_odata, d0_rdy}, 64'h0);
        @(posedge clk);
        #1;
        d0_data = defdata();
        q0.push_back(mk(0, 32'hA0000000));
        rst_n = 1'b1;
        #1;
        chk("post-reset rdy", {60'h0, d0_rdy}, {60'h0, 4'b0001});
        @(posedge clk);
        #1;
        d0_valid = 4'h0;
        @(posedge clk);
        #1;

        d0_data[2*32 +: 32] = 32'h12345678;
        d0_valid = 4'b0100;
        d0_ordy = 0;
        q0.push_back(mk(2, 32'h12345678));
        q0.push_back(mk(1, 32'hA0000001));
        @(posedge clk);
        #1;
        d0_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            chk("hold", {d0_ov, d0_osel, d0_odata, d0_rdy},
                {1'b1, 2'd2, 32'h12345678, 4'b0000});
            @(posedge clk);
            #1;
        end
        d0_ordy = 1;
        #1;
        chk("release rdy", {60'h0, d0_rdy}, {60'h0, 4'b0010});
        @(posedge clk);
        #1;
        d0_valid = 4'h0;
        @(posedge clk);
        #1;

        d0_data = defdata();
        d0_fen = 1;
        d0_fsel = 2'd3;
        d0_valid = 4'b1001;
        q0.push_back(mk(3, 32'hA0000003));
        q0.push_back(mk(0, 32'hA0000000));
        #1;
        chk("force rdy", {60'h0, d0_rdy}, {60'h0, 4'b1000});
        @(posedge clk);
        #1;
        d0_valid = 4'b0001;
        #1;
        chk("force empty", {60'h0, d0_rdy}, 64'h0);
        @(posedge clk);
        #1;
        chk("force no grant", {63'h0, d0_ov}, 64'h0);
        d0_fen = 0;
        d0_valid = 4'b0011;
        #1;
        chk("ptr after force", {60'h0, d0_rdy}, {60'h0, 4'b0001});
        @(posedge clk);
        #1;
        d0_valid = 4'h0;
        @(posedge clk);
        #1;

        d1_valid = 4'b1010;
        q1.push_back(mk(1, 32'hA0000001));
        q1.push_back(mk(1, 32'hA0000001));
        q1.push_back(mk(1, 32'hA0000001));
        q1.push_back(mk(3, 32'hA0000003));
        #1;
        chk("fp rdy", {60'h0, d1_rdy}, {60'h0, 4'b0010});
        repeat (3) @(posedge clk);
        #1;
        d1_valid = 4'b1000;
        @(posedge clk);
        #1;
        d1_valid = 4'h0;
        @(posedge clk);
        #1;

        d2_fen = 1;
        d2_fsel = 1'b1;
        d2_valid = 2'b11;
        q2.push_back(mk(1, 32'h000000A5));
        #1;
        chk("n2 rdy", {62'h0, d2_rdy}, {62'h0, 2'b10});
        @(posedge clk);
        #1;
        d2_valid = 2'b00;
        @(posedge clk);
        #1;
        chk("n2 drain", {d2_ov, d2_osel, d2_odata}, {1'b0, 1'b1, 8'hA5});

        @(posedge clk);
        #1;
        chk("q0 empty", 64'(q0.size()), 64'h0);
        chk("q1 empty", 64'(q1.size()), 64'h0);
        chk("q2 empty", 64'(q2.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
